// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller and the pipe registers.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_ctrl_state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // A source operand depends on rd only if it is actually read and rd is not x0.
  function automatic logic reg_match(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
    return uses && (rs == rd) && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for debug event counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use stalls, branch squashes and
// multi-cycle data-memory freezes with timeout, plus saturating debug counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             pc_select,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             mem_start,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             bubble_mem_wb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT - 1);

  pipe_ctrl_state_t state_reg;
  logic [TO_W-1:0]  wait_cnt_reg;
  logic             mem_err_reg;

  logic launch;
  logic release_now;
  logic frozen;
  logic load_use;
  logic branch_flush;
  logic lu_stall;

  always_comb begin
    launch       = (state_reg == RUN) && mem_req;
    release_now  = (state_reg == MEM_WAIT) && (mem_ready || (wait_cnt_reg == WAIT_LAST));
    frozen       = launch || ((state_reg == MEM_WAIT) && !release_now);
    load_use     = ex_is_load && (reg_match(id_uses_rs1, id_rs1, ex_rd) ||
                                  reg_match(id_uses_rs2, id_rs2, ex_rd));
    branch_flush = !frozen && pc_select;
    lu_stall     = !frozen && !pc_select && load_use;
  end

  // Outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    mem_start     = reset && launch;
    stall_pc      = reset && (frozen || lu_stall);
    stall_if_id   = reset && (frozen || lu_stall);
    stall_id_ex   = reset && frozen;
    stall_ex_mem  = reset && frozen;
    bubble_mem_wb = reset && frozen;
    flush_if_id   = reset && branch_flush;
    flush_id_ex   = reset && (branch_flush || lu_stall);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (mem_req) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= '0;
          end
        end
        MEM_WAIT: begin
          // A mem_req seen in the release cycle is the next instruction; RUN picks it up.
          if (release_now) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            if (!mem_ready) begin
              mem_err_reg <= 1'b1;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
          end
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign mem_err = mem_err_reg;

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = stall_pc;
  assign cnt_inc[1] = flush_if_id;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc[gi]),
        .clr   (1'b0),
        .value (cnt_val[gi])
      );
    end
  endgenerate

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus queues expected per-cycle outputs, a negedge monitor checks them.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load, pc_select, mem_req, mem_ready;
  logic       mem_start, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic       flush_if_id, flush_id_ex, bubble_mem_wb, mem_err;
  logic [3:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(4), .TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .pc_select(pc_select),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_start(mem_start),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .bubble_mem_wb(bubble_mem_wb), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // ctrl = {mem_start, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, bubble_mem_wb}
  localparam logic [7:0] C_IDLE   = 8'b0000_0000;
  localparam logic [7:0] C_LAUNCH = 8'b1111_1001;
  localparam logic [7:0] C_FREEZE = 8'b0111_1001;
  localparam logic [7:0] C_LU     = 8'b0110_0010;
  localparam logic [7:0] C_BR     = 8'b0000_0110;

  typedef struct {
    string      name;
    logic [7:0] ctrl;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [7:0] ctrl_now();
    return {mem_start, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
            flush_if_id, flush_id_ex, bubble_mem_wb};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      x = exp_q.pop_front();
      $display("txn %-10s ctrl=%b err=%b stall_cnt=%0d flush_cnt=%0d", x.name, ctrl_now(), mem_err, stall_cnt, flush_cnt);
      chk({x.name, ".ctrl"}, 32'(ctrl_now()), 32'(x.ctrl));
      chk({x.name, ".err"}, 32'(mem_err), 32'(x.err));
      chk({x.name, ".cnt"}, {24'd0, stall_cnt, flush_cnt}, {24'd0, x.sc, x.fc});
    end
  end

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic [4:0] rd, input logic ld, input logic pcs, input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; pc_select = pcs; mem_req = req; mem_ready = rdy;
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue the expectation for the current cycle, then advance to 1 time unit after the next edge.
  task automatic cyc(input string nm, input logic [7:0] c, input logic e, input int sc, input int fc);
    exp_t x;
    x.name = nm; x.ctrl = c; x.err = e; x.sc = 4'(sc); x.fc = 4'(fc);
    exp_q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".ctrl"}, 32'(ctrl_now()), 32'(C_IDLE));
    chk({nm, ".err"}, 32'(mem_err), 32'd0);
    chk({nm, ".cnt"}, {24'd0, stall_cnt, flush_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    #2;
    chk_all_zero("reset_state");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Load-use hazards and non-hazards
    drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);  cyc("lu_rs1", C_LU, 0, 0, 0);
    drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);  cyc("lu_bub", C_IDLE, 0, 1, 0);
    drv(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);  cyc("lu_rs2", C_LU, 0, 1, 0);
    idle();                                                      cyc("lu_bub2", C_IDLE, 0, 2, 0);
    drv(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);  cyc("no_use", C_IDLE, 0, 2, 0);
    drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);  cyc("not_load", C_IDLE, 0, 2, 0);
    drv(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);  cyc("load_x0", C_IDLE, 0, 2, 0);
    drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);  cyc("br_haz", C_BR, 0, 2, 0);
    idle();                                                      cyc("br_after", C_IDLE, 0, 2, 1);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  cyc("rdy_run", C_IDLE, 0, 2, 1);

    // Memory handshake, ready on the 4th wait cycle (also the timeout cycle: ready wins)
    do_reset();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);  cyc("m_launch", C_LAUNCH, 0, 0, 0);
    cyc("m_w0", C_FREEZE, 0, 1, 0);
    cyc("m_w1", C_FREEZE, 0, 2, 0);
    cyc("m_w2", C_FREEZE, 0, 3, 0);
    mem_ready = 1'b1;                                            cyc("m_rel", C_IDLE, 0, 4, 0);
    idle();                                                      cyc("m_after", C_IDLE, 0, 4, 0);

    // Timeout with no ready
    do_reset();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);  cyc("t_launch", C_LAUNCH, 0, 0, 0);
    idle();
    cyc("t_w0", C_FREEZE, 0, 1, 0);
    cyc("t_w1", C_FREEZE, 0, 2, 0);
    cyc("t_w2", C_FREEZE, 0, 3, 0);
    cyc("t_rel", C_IDLE, 0, 4, 0);
    cyc("t_err", C_IDLE, 1, 4, 0);
    cyc("t_sticky", C_IDLE, 1, 4, 0);

    // Branch pending across a freeze is acted on in the release cycle
    do_reset();
    idle();                                                      cyc("rst_clr", C_IDLE, 0, 0, 0);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);  cyc("b_launch", C_LAUNCH, 0, 0, 0);
    cyc("b_w0", C_FREEZE, 0, 1, 0);
    mem_ready = 1'b1;                                            cyc("b_rel", C_BR, 0, 2, 0);
    idle();                                                      cyc("b_after", C_IDLE, 0, 2, 1);

    // Stall counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc($sformatf("sat%0d", i), C_LU, 0, (i > 15) ? 15 : i, 0);
    end
    idle();                                                      cyc("sat_end", C_IDLE, 0, 15, 0);

    // Set mem_err, then reset asynchronously mid-MEM_WAIT
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);  cyc("r_launch", C_LAUNCH, 0, 15, 0);
    idle();
    cyc("r_w0", C_FREEZE, 0, 15, 0);
    cyc("r_w1", C_FREEZE, 0, 15, 0);
    cyc("r_w2", C_FREEZE, 0, 15, 0);
    cyc("r_rel", C_IDLE, 0, 15, 0);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);  cyc("r2_launch", C_LAUNCH, 1, 15, 0);
    cyc("r2_w0", C_FREEZE, 1, 15, 0);
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("rst_held");
    reset = 1'b1;
    cyc("post_rst", C_LAUNCH, 0, 0, 0);
    mem_ready = 1'b1;                                            cyc("post_w0", C_IDLE, 0, 1, 0);
    idle();                                                      cyc("post_idle", C_IDLE, 0, 1, 0);

    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
